// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned CLA_LATENCY = 3;

  // Number of lookahead groups covering width bits; the last group may be partial.
  function automatic int unsigned cla_num_groups(input int unsigned width, input int unsigned fanin);
    return (width + fanin - 1) / fanin;
  endfunction

  // Number of tree levels until a single group remains.
  function automatic int unsigned cla_tree_depth(input int unsigned width, input int unsigned fanin);
    int unsigned w;
    int unsigned d;
    w = width;
    d = 1;
    while (w > fanin) begin
      w = cla_num_groups(w, fanin);
      d++;
    end
    return d;
  endfunction

endpackage

// File: rtl/cla_group_carry_gen.sv
// Recursive group-lookahead carry tree: one level of group P/G, recurse, expand down.
module cla_group_carry_gen
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FANIN = 4
) (
  input  logic             c_in,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] g,
  output logic [WIDTH:0]   c
);

  localparam int unsigned NUM_GROUPS = cla_num_groups(WIDTH, FANIN);

  if (NUM_GROUPS == 1) begin : g_leaf
    logic [WIDTH:0] cv;

    // Single group closes the recursion: carries straight from c_in.
    always_comb begin
      cv    = '0;
      cv[0] = c_in;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cv[i+1] = g[i] | (p[i] & cv[i]);
      end
    end

    assign c = cv;
  end else begin : g_tree
    logic [NUM_GROUPS-1:0] grp_p;
    logic [NUM_GROUPS-1:0] grp_g;
    logic [NUM_GROUPS:0]   grp_c;

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
      localparam int unsigned BASE = FANIN * k;
      localparam int unsigned SIZE = (k == NUM_GROUPS - 1) ? (WIDTH - BASE) : FANIN;
      logic            gp;
      logic            gg;
      logic [SIZE-1:0] cl;

      // Group propagate is the AND of members; group generate is the prefix generate.
      always_comb begin
        gp = 1'b1;
        gg = 1'b0;
        for (int unsigned j = 0; j < SIZE; j++) begin
          gg = g[BASE+j] | (p[BASE+j] & gg);
          gp = gp & p[BASE+j];
        end
      end

      assign grp_p[k] = gp;
      assign grp_g[k] = gg;

      // Expand the group carry-in across the member bits.
      always_comb begin
        cl    = '0;
        cl[0] = grp_c[k];
        for (int unsigned j = 0; j + 1 < SIZE; j++) begin
          cl[j+1] = g[BASE+j] | (p[BASE+j] & cl[j]);
        end
      end

      assign c[BASE +: SIZE] = cl;
    end

    cla_group_carry_gen #(
      .WIDTH(NUM_GROUPS),
      .FANIN(FANIN)
    ) u_upper (
      .c_in(c_in),
      .p   (grp_p),
      .g   (grp_g),
      .c   (grp_c)
    );

    assign c[WIDTH] = grp_c[NUM_GROUPS];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage elastic carry-lookahead adder/subtractor with valid/ready handshake.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FANIN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  logic             valid0;
  logic             valid1;
  logic             rdy0;
  logic             rdy1;
  logic             rdy2;
  logic             accept0;
  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p0;
  logic [WIDTH-1:0] g0;
  logic             c0;
  logic [WIDTH:0]   carry_c;
  logic [WIDTH:0]   carry1;
  logic [WIDTH-1:0] p1;

  // Per-stage ready: an empty stage always accepts, so bubbles collapse.
  always_comb begin
    rdy2    = ~o_valid | i_ready;
    rdy1    = ~valid1 | rdy2;
    rdy0    = ~valid0 | rdy1;
    accept0 = i_valid & rdy0;
    adv1    = valid0 & rdy1;
    adv2    = valid1 & rdy2;
  end

  assign o_ready = rdy0;
  assign b_eff   = i_sub ? ~i_b : i_b;

  // Stage valid flags; a stalled stage keeps its flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid0  <= 1'b0;
      valid1  <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      if (rdy0) valid0  <= i_valid;
      if (rdy1) valid1  <= valid0;
      if (rdy2) o_valid <= valid1;
    end
  end

  // S0: capture bitwise propagate/generate and the effective carry-in.
  always_ff @(posedge i_clk) begin
    if (accept0) begin
      p0 <= i_a ^ b_eff;
      g0 <= i_a & b_eff;
      c0 <= i_sub | i_cin;
    end
  end

  cla_group_carry_gen #(
    .WIDTH(WIDTH),
    .FANIN(FANIN)
  ) u_carry (
    .c_in(c0),
    .p   (p0),
    .g   (g0),
    .c   (carry_c)
  );

  // S1: register the full carry vector alongside propagate.
  always_ff @(posedge i_clk) begin
    if (adv1) begin
      carry1 <= carry_c;
      p1     <= p0;
    end
  end

  // S2: form sum, carry-out and signed overflow; held while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sum  <= '0;
      o_cout <= 1'b0;
      o_ovf  <= 1'b0;
    end else if (adv2) begin
      o_sum  <= p1 ^ carry1[WIDTH-1:0];
      o_cout <= carry1[WIDTH];
      o_ovf  <= carry1[WIDTH] ^ carry1[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed corners, backpressure, bubbles, reset and width sweep.
module tb_cla_pipe_adder;
  import cla_pkg::*;

  localparam int unsigned SW_N = 200;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        i_cin;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_sum;
  logic        o_cout;
  logic        o_ovf;

  logic        sw_valid;
  logic [63:0] sw_a;
  logic [63:0] sw_b;
  logic        sw_cin;
  logic        sw_sub;
  logic        rdy13, v13, co13, ov13;
  logic [12:0] s13;
  logic        rdy64, v64, co64, ov64;
  logic [63:0] s64;
  logic        rdy8, v8, co8, ov8;
  logic [7:0]  s8;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  logic chk_lat = 1'b0;

  cla_pipe_adder #(.WIDTH(16), .FANIN(4)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_cin(i_cin), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf)
  );

  cla_pipe_adder #(.WIDTH(13), .FANIN(4)) u_w13 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(sw_valid), .o_ready(rdy13),
    .i_a(sw_a[12:0]), .i_b(sw_b[12:0]), .i_cin(sw_cin), .i_sub(sw_sub),
    .o_valid(v13), .i_ready(1'b1), .o_sum(s13), .o_cout(co13), .o_ovf(ov13)
  );

  cla_pipe_adder #(.WIDTH(64), .FANIN(2)) u_w64 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(sw_valid), .o_ready(rdy64),
    .i_a(sw_a), .i_b(sw_b), .i_cin(sw_cin), .i_sub(sw_sub),
    .o_valid(v64), .i_ready(1'b1), .o_sum(s64), .o_cout(co64), .o_ovf(ov64)
  );

  cla_pipe_adder #(.WIDTH(8), .FANIN(8)) u_w8 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(sw_valid), .o_ready(rdy8),
    .i_a(sw_a[7:0]), .i_b(sw_b[7:0]), .i_cin(sw_cin), .i_sub(sw_sub),
    .o_valid(v8), .i_ready(1'b1), .o_sum(s8), .o_cout(co8), .o_ovf(ov8)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Arithmetic reference: plain integer add/subtract and signed range test.
  task automatic model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub,
                       output logic [63:0] s, output logic co, output logic ov);
    logic [65:0]        mask, ua, ub, ut;
    logic signed [65:0] sa, sbv, st, lim;
    mask = (66'd1 << w) - 66'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    sa   = $signed(ua);
    sbv  = $signed(ub);
    if (ua[w-1]) sa  = sa - (66'sd1 <<< w);
    if (ub[w-1]) sbv = sbv - (66'sd1 <<< w);
    if (sub) begin
      ut = ua - ub;
      co = (ua >= ub);
      st = sa - sbv;
    end else begin
      ut = ua + ub + 66'(cin);
      co = ut[w];
      st = sa + sbv + $signed({65'd0, cin});
    end
    lim = 66'sd1 <<< (w - 1);
    ov  = (st >= lim) || (st < -lim);
    s   = ut[63:0] & mask[63:0];
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle on the main DUT: drive, score the output, record an accept, advance.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic rdy);
    exp_t        e;
    logic [63:0] ms;
    logic        mco, mov;
    i_valid = v; i_a = a; i_b = b; i_cin = cin; i_sub = sub; i_ready = rdy;
    #1;
    if (o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(o_valid), 64'(0));
      end else if (i_ready) begin
        e = sb.pop_front();
        check("sum", 64'(o_sum), 64'(e.s));
        check("cout", 64'(o_cout), 64'(e.co));
        check("ovf", 64'(o_ovf), 64'(e.ov));
        if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(CLA_LATENCY));
      end
    end
    if (v && o_ready) begin
      model(16, 64'(a), 64'(b), cin, sub, ms, mco, mov);
      e.s = ms[15:0]; e.co = mco; e.ov = mov; e.cyc = cyc;
      sb.push_back(e);
      n_acc++;
    end
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] es, input logic eco, input logic eov);
    step(1'b1, a, b, cin, sub, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    i_valid = 1'b0; i_ready = 1'b1;
    #1;
    check({tag, "_valid"}, 64'(o_valid), 64'(1));
    check({tag, "_sum"}, 64'(o_sum), 64'(es));
    check({tag, "_cout"}, 64'(o_cout), 64'(eco));
    check({tag, "_ovf"}, 64'(o_ovf), 64'(eov));
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [63:0] e_s  [3][SW_N];
    logic        e_co [3][SW_N];
    logic        e_ov [3][SW_N];
    logic [63:0] obs_s [3];
    logic        obs_v [3];
    logic        obs_co [3];
    logic        obs_ov [3];
    int unsigned sw_w [3];
    int          acc_start;
    int          guard;

    sw_w[0] = 13; sw_w[1] = 64; sw_w[2] = 8;
    i_rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_cin = 1'b0; i_sub = 1'b0; i_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;

    // Reset values.
    #1;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_sum", 64'(o_sum), 64'(0));
    check("rst_cout", 64'(o_cout), 64'(0));
    check("rst_ovf", 64'(o_ovf), 64'(0));
    check("rst_ready", 64'(o_ready), 64'(1));
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);

    // Directed corners.
    chk_lat = 1'b1;
    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_brw",  16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_cin",  16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("add_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: downstream stalled from the start.
    chk_lat = 1'b0;
    acc_start = n_acc;
    for (int i = 0; i < 6; i++)
      step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    check("bp_accepts", 64'(n_acc - acc_start), 64'(3));
    i_valid = 1'b1; i_ready = 1'b0;
    #1;
    check("bp_ready_low", 64'(o_ready), 64'(0));
    check("bp_valid_held", 64'(o_valid), 64'(1));
    check("bp_sum_held", 64'(o_sum), 64'(sb[0].s));
    i_valid = 1'b0; i_ready = 1'b1;
    #1;
    check("bp_ready_rise", 64'(o_ready), 64'(1));
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("bp_drained", 64'(sb.size()), 64'(0));

    // Alternating valid with random downstream stalls.
    acc_start = n_acc;
    for (int i = 0; i < 40000 && (n_acc - acc_start) < 10000; i++)
      step((i % 2) == 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) != 0);
    check("rand_count", 64'(n_acc - acc_start), 64'(10000));
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    check("rand_drained", 64'(sb.size()), 64'(0));

    // Asynchronous reset with two transactions in flight.
    chk_lat = 1'b1;
    step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    i_valid = 1'b0; i_ready = 1'b0;
    #1;
    check("pre_rst_valid", 64'(o_valid), 64'(1));
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(o_valid), 64'(0));
    check("mid_rst_sum", 64'(o_sum), 64'(0));
    check("mid_rst_ready", 64'(o_ready), 64'(1));
    sb.delete();
    @(negedge i_clk);
    #2 i_rst_n = 1'b1;
    @(negedge i_clk);
    step(1'b1, 16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b0; i_ready = 1'b1;
      #1;
      check("post_rst_quiet", 64'(o_valid), 64'(0));
      @(negedge i_clk);
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    #1;
    check("post_rst_valid", 64'(o_valid), 64'(1));
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("post_rst_drained", 64'(sb.size()), 64'(0));

    // Width/fan-in sweep: partial group, deep tree, single group.
    for (int t = 0; t < int'(SW_N) + 3; t++) begin
      if (t < int'(SW_N)) begin
        sw_valid = 1'b1;
        if (t == 0) begin
          sw_a = '1; sw_b = '0; sw_cin = 1'b1; sw_sub = 1'b0;
        end else begin
          sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom};
          sw_cin = 1'($urandom); sw_sub = 1'($urandom);
        end
        for (int d = 0; d < 3; d++)
          model(sw_w[d], sw_a, sw_b, sw_cin, sw_sub, e_s[d][t], e_co[d][t], e_ov[d][t]);
      end else begin
        sw_valid = 1'b0;
      end
      #1;
      obs_v[0] = v13; obs_s[0] = 64'(s13); obs_co[0] = co13; obs_ov[0] = ov13;
      obs_v[1] = v64; obs_s[1] = s64;      obs_co[1] = co64; obs_ov[1] = ov64;
      obs_v[2] = v8;  obs_s[2] = 64'(s8);  obs_co[2] = co8;  obs_ov[2] = ov8;
      if (t >= 3) begin
        for (int d = 0; d < 3; d++) begin
          check($sformatf("sw%0d_valid", sw_w[d]), 64'(obs_v[d]), 64'(1));
          check($sformatf("sw%0d_sum", sw_w[d]), obs_s[d], e_s[d][t-3]);
          check($sformatf("sw%0d_cout", sw_w[d]), 64'(obs_co[d]), 64'(e_co[d][t-3]));
          check($sformatf("sw%0d_ovf", sw_w[d]), 64'(obs_ov[d]), 64'(e_ov[d][t-3]));
          if (t == 3) begin
            check($sformatf("sw%0d_ones_sum", sw_w[d]), obs_s[d], 64'(0));
            check($sformatf("sw%0d_ones_cout", sw_w[d]), 64'(obs_co[d]), 64'(1));
          end
        end
      end
      @(negedge i_clk);
    end
    #1;
    check("sw_idle", 64'({v13, v64, v8}), 64'(0));
    check("sw_ready", 64'({rdy13, rdy64, rdy8}), 64'(7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
